sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one external asynchronous 16-bit SRAM (20-bit address, byte enables, active-low CE1/OE/WE) between two requester ports, e.g. a data-capture writer and a readout reader.
- Grants port access round-robin and sequences SRAM strobe timing with programmable write-pulse and read-wait lengths.
- Owns the bidirectional SRAM data bus and guarantees a strobe-free turnaround cycle between accesses.
- Sits between the FIFO/readout cores and the SRAM pins in the FPGA top level.

Parameters:
WR_PULSE, 1, number of cycles SRAM_WE_B is held low per write (1..15)
RD_WAIT, 2, number of cycles SRAM_OE_B is held low before read data is captured (1..15)

Ports:
BUS_CLK  input  1  single clock for all logic
BUS_RST  input  1  synchronous, active-high reset
REQ0 / REQ1  input  1  access request; port holds it and its payload stable until ACK
WE0 / WE1  input  1  1 = write, 0 = read
ADDR0 / ADDR1  input  20  word address
WDATA0 / WDATA1  input  16  write data
BE0 / BE1  input  2  byte enables, active high; bit1 = upper byte
ACK0 / ACK1  output  1  one-cycle completion pulse
RDATA0 / RDATA1  output  16  read data; valid while ACKn is high, then held until the next read on that port
SRAM_A  output  20  SRAM address
SRAM_IO  inout  16  SRAM data bus
SRAM_BHE_B / SRAM_BLE_B  output  1  active-low byte enables
SRAM_CE1_B / SRAM_OE_B / SRAM_WE_B  output  1  active-low SRAM strobes
BUSY  output  1  high in any state other than IDLE

Behaviour:
- Reset values: ACKn=0, RDATAn=0, SRAM_A=0, all SRAM_*_B=1, SRAM_IO=Z, BUSY=0, state=IDLE, last_gnt=1 so port 0 wins the first tie.
- States: IDLE, W_SETUP, W_PULSE, W_HOLD, R_WAIT, DONE. All outputs are registered.
- IDLE, arbitration:
  - If exactly one REQn is high, grant that port.
  - If both are high, grant the port other than last_gnt.
  - On grant, latch the port's WE/ADDR/WDATA/BE and update last_gnt.
  - Next state is W_SETUP if WE=1, otherwise R_WAIT.
- Write sequence:
  - W_SETUP, 1 cycle: CE1_B=0, address and BHE_B/BLE_B (=~BE) driven, SRAM_IO driven with WDATA, WE_B=1.
  - W_PULSE, WR_PULSE cycles: WE_B=0, everything else held.
  - W_HOLD, 1 cycle: WE_B=1 with address and data still driven.
  - Then DONE.
- Read sequence:
  - R_WAIT, RD_WAIT cycles: CE1_B=0, OE_B=0, SRAM_IO=Z, address and byte enables driven.
  - All 16 bits of SRAM_IO are captured into RDATAn on the last R_WAIT edge.
  - Then DONE.
- DONE, 1 cycle:
  - ACKn=1 for the granted port only.
  - All strobes are high, SRAM_IO=Z, SRAM_A holds its last value.
  - No arbitration takes place in DONE; it is the turnaround cycle. Next state is IDLE.
- Latency, counted from the IDLE cycle with the grant (cycle 0):
  - Write: ACK in cycle WR_PULSE+3; minimum back-to-back period WR_PULSE+4.
  - Read: ACK in cycle RD_WAIT+1; minimum back-to-back period RD_WAIT+2.
- SRAM_IO is driven only in W_SETUP, W_PULSE and W_HOLD. WE_B and OE_B are never low in the same cycle.
- Once granted, an access always completes. REQ dropping mid-access is ignored, and payload changes after the grant are ignored.
- A port requesting continuously while the other is idle is re-granted every period; there is no forced idle gap beyond DONE/IDLE.
- BE=2'b00 still performs the full strobe sequence, with both byte enables high (inactive).
- BUSY=1 in every state except IDLE.
- BUS_RST asserted mid-access: on the next edge the state returns to IDLE and all strobes deassert. No ACK is issued; the aborted write leaves SRAM contents undefined at that address.

Test Plan:
- Write then read on port 0 (WR_PULSE=1, RD_WAIT=2):
  - Stimulus: write ADDR0=0x00012, WDATA0=0xBEEF, BE0=2'b11; then a read of the same address.
  - Required: WE_B low for exactly 1 cycle; ACK0 in cycle 4 of the write; read ACK0 in cycle 3 with RDATA0=0xBEEF.
- Simultaneous requests from reset:
  - Stimulus: REQ0 and REQ1 both held high, each doing reads.
  - Required: grant order 0,1,0,1; ACK0 and ACK1 never high together; ACK spacing 4 cycles.
- Byte-lane write:
  - Stimulus: write 0xFFFF to 0x00100, then write 0x1234 with BE1=2'b01, then read on port 1.
  - Required: BHE_B=1 and BLE_B=0 during the byte write; read returns 0xFF34.
- Parameter sweep:
  - Stimulus: WR_PULSE=3, RD_WAIT=4.
  - Required: WE_B low for exactly 3 consecutive cycles; OE_B low for exactly 4; write ACK at cycle 6, read ACK at cycle 5.
- Bus discipline, checked by assertion on every cycle of the above tests:
  - SRAM_IO is never driven while OE_B=0.
  - At least one cycle has all strobes high between any two accesses.
  - CE1_B=1 whenever BUSY=0.
- Reset mid-write:
  - Stimulus: BUS_RST pulsed during W_PULSE.
  - Required: next cycle shows WE_B=1, CE1_B=1, SRAM_IO=Z and BUSY=0; no ACK; a subsequent REQ1 read is served normally.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter and strobe sequencer for an external asynchronous 16-bit SRAM.
// Owns the bidirectional data bus; every access ends in a strobe-free DONE turnaround cycle.
`timescale 1ns/1ps

module sram_port_arbiter #(
    parameter int unsigned WR_PULSE = 1,
    parameter int unsigned RD_WAIT  = 2
) (
    input  logic        BUS_CLK,
    input  logic        BUS_RST,
    input  logic        REQ0,
    input  logic        REQ1,
    input  logic        WE0,
    input  logic        WE1,
    input  logic [19:0] ADDR0,
    input  logic [19:0] ADDR1,
    input  logic [15:0] WDATA0,
    input  logic [15:0] WDATA1,
    input  logic [1:0]  BE0,
    input  logic [1:0]  BE1,
    output logic        ACK0,
    output logic        ACK1,
    output logic [15:0] RDATA0,
    output logic [15:0] RDATA1,
    output logic [19:0] SRAM_A,
    inout  wire  [15:0] SRAM_IO,
    output logic        SRAM_BHE_B,
    output logic        SRAM_BLE_B,
    output logic        SRAM_CE1_B,
    output logic        SRAM_OE_B,
    output logic        SRAM_WE_B,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        StIdle, StWSetup, StWPulse, StWHold, StRWait, StDone
    } state_t;

    localparam logic [3:0] WrLast = 4'(WR_PULSE - 1);
    localparam logic [3:0] RdLast = 4'(RD_WAIT - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        last_gnt_q;
    logic        gnt_q;
    logic        io_oe_q;
    logic [15:0] io_out_q;

    logic        pick;
    logic        sel_we;
    logic [19:0] sel_addr;
    logic [15:0] sel_wdata;
    logic [1:0]  sel_be;

    // With both ports requesting, the one not served last wins.
    always_comb begin
        pick      = (REQ0 && REQ1) ? ~last_gnt_q : REQ1;
        sel_we    = pick ? WE1    : WE0;
        sel_addr  = pick ? ADDR1  : ADDR0;
        sel_wdata = pick ? WDATA1 : WDATA0;
        sel_be    = pick ? BE1    : BE0;
    end

    assign SRAM_IO = io_oe_q ? io_out_q : 16'bz;

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            last_gnt_q <= 1'b1;
            gnt_q      <= 1'b0;
            io_oe_q    <= 1'b0;
            io_out_q   <= '0;
            ACK0       <= 1'b0;
            ACK1       <= 1'b0;
            RDATA0     <= '0;
            RDATA1     <= '0;
            SRAM_A     <= '0;
            SRAM_BHE_B <= 1'b1;
            SRAM_BLE_B <= 1'b1;
            SRAM_CE1_B <= 1'b1;
            SRAM_OE_B  <= 1'b1;
            SRAM_WE_B  <= 1'b1;
            BUSY       <= 1'b0;
        end else begin
            ACK0 <= 1'b0;
            ACK1 <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (REQ0 || REQ1) begin
                        gnt_q      <= pick;
                        last_gnt_q <= pick;
                        SRAM_A     <= sel_addr;
                        SRAM_BHE_B <= ~sel_be[1];
                        SRAM_BLE_B <= ~sel_be[0];
                        SRAM_CE1_B <= 1'b0;
                        BUSY       <= 1'b1;
                        if (sel_we) begin
                            state_q  <= StWSetup;
                            io_out_q <= sel_wdata;
                            io_oe_q  <= 1'b1;
                        end else begin
                            state_q   <= StRWait;
                            SRAM_OE_B <= 1'b0;
                            cnt_q     <= RdLast;
                        end
                    end
                end
                StWSetup: begin
                    state_q   <= StWPulse;
                    SRAM_WE_B <= 1'b0;
                    cnt_q     <= WrLast;
                end
                StWPulse: begin
                    if (cnt_q == 4'd0) begin
                        state_q   <= StWHold;
                        SRAM_WE_B <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StWHold: begin
                    state_q    <= StDone;
                    SRAM_CE1_B <= 1'b1;
                    io_oe_q    <= 1'b0;
                    ACK0       <= ~gnt_q;
                    ACK1       <= gnt_q;
                end
                StRWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q    <= StDone;
                        SRAM_CE1_B <= 1'b1;
                        SRAM_OE_B  <= 1'b1;
                        ACK0       <= ~gnt_q;
                        ACK1       <= gnt_q;
                        if (gnt_q) RDATA1 <= SRAM_IO;
                        else       RDATA0 <= SRAM_IO;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    BUSY    <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: instance A (WR_PULSE=1, RD_WAIT=2) runs against a
// behavioural SRAM, instance B (WR_PULSE=3, RD_WAIT=4) checks strobe widths and bus drive.
`timescale 1ns/1ps

module tb_sram_port_arbiter;

    localparam int WP_A = 1;
    localparam int RW_A = 2;
    localparam int WP_B = 3;
    localparam int RW_B = 4;
    localparam logic [15:0] B_WD = 16'hA5C3;

    typedef struct packed {
        logic        rd;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst;
    logic        req [2];
    logic        wr [2];
    logic [19:0] addr [2];
    logic [15:0] wdata [2];
    logic [1:0]  be [2];
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic [19:0] a_a;
    wire  [15:0] a_io;
    logic        a_bhe, a_ble, a_ce, a_oe, a_we, a_busy;

    logic        b_req, b_wr;
    logic [19:0] b_addr;
    logic [1:0]  b_be;
    logic        b_ack0, b_ack1;
    logic [15:0] b_rdata0, b_rdata1;
    logic [19:0] b_a;
    wire  [15:0] b_io;
    logic        b_bhe, b_ble, b_ce, b_oe, b_we, b_busy;

    sram_port_arbiter #(.WR_PULSE(WP_A), .RD_WAIT(RW_A)) dut_a (
        .BUS_CLK(clk), .BUS_RST(rst),
        .REQ0(req[0]), .REQ1(req[1]), .WE0(wr[0]), .WE1(wr[1]),
        .ADDR0(addr[0]), .ADDR1(addr[1]), .WDATA0(wdata[0]), .WDATA1(wdata[1]),
        .BE0(be[0]), .BE1(be[1]), .ACK0(ack0), .ACK1(ack1),
        .RDATA0(rdata0), .RDATA1(rdata1), .SRAM_A(a_a), .SRAM_IO(a_io),
        .SRAM_BHE_B(a_bhe), .SRAM_BLE_B(a_ble), .SRAM_CE1_B(a_ce),
        .SRAM_OE_B(a_oe), .SRAM_WE_B(a_we), .BUSY(a_busy)
    );

    sram_port_arbiter #(.WR_PULSE(WP_B), .RD_WAIT(RW_B)) dut_b (
        .BUS_CLK(clk), .BUS_RST(rst),
        .REQ0(b_req), .REQ1(1'b0), .WE0(b_wr), .WE1(1'b0),
        .ADDR0(b_addr), .ADDR1(20'h0), .WDATA0(B_WD), .WDATA1(16'h0),
        .BE0(b_be), .BE1(2'b00), .ACK0(b_ack0), .ACK1(b_ack1),
        .RDATA0(b_rdata0), .RDATA1(b_rdata1), .SRAM_A(b_a), .SRAM_IO(b_io),
        .SRAM_BHE_B(b_bhe), .SRAM_BLE_B(b_ble), .SRAM_CE1_B(b_ce),
        .SRAM_OE_B(b_oe), .SRAM_WE_B(b_we), .BUSY(b_busy)
    );

    // Behavioural asynchronous SRAM behind instance A.
    logic [15:0] sram_mem [logic [19:0]];
    logic [15:0] sram_q = '0;
    assign a_io = (!a_ce && !a_oe && a_we) ? sram_q : 16'bz;

    always @(negedge clk) sram_q = sram_mem.exists(a_a) ? sram_mem[a_a] : 16'h0;

    always @(posedge clk) begin
        logic [15:0] old;
        if (!a_ce && !a_we) begin
            old = sram_mem.exists(a_a) ? sram_mem[a_a] : 16'h0;
            if (!a_ble) old[7:0] = a_io[7:0];
            if (!a_bhe) old[15:8] = a_io[15:8];
            sram_mem[a_a] = old;
        end
    end

    // Reference model: word memory with byte-masked writes.
    logic [15:0] ref_mem [logic [19:0]];

    function automatic logic [15:0] ref_rd(input logic [19:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
    endfunction

    task automatic ref_wr(input logic [19:0] a, input logic [15:0] d, input logic [1:0] b);
        logic [15:0] m;
        m = {{8{b[1]}}, {8{b[0]}}};
        ref_mem[a] = (ref_rd(a) & ~m) | (d & m);
    endtask

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    exp_t q0[$];
    exp_t q1[$];
    int   log_p[$];
    int   log_c[$];

    task automatic access(input int p, input logic w, input logic [19:0] a,
                          input logic [15:0] d, input logic [1:0] b, output int lat);
        exp_t e;
        int   t0;
        bit   got;
        e.rd   = !w;
        e.data = w ? 16'h0 : ref_rd(a);
        if (w) ref_wr(a, d, b);
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clk); #1;
        wr[p] = w; addr[p] = a; wdata[p] = d; be[p] = b; req[p] = 1'b1;
        t0  = cyc;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if ((p == 0) ? ack0 : ack1) got = 1'b1;
        end
        lat = cyc - t0;
        chk($sformatf("ack_arrives_port%0d", p), 32'(got), 32'd1);
        @(posedge clk); #1;
        req[p] = 1'b0;
    endtask

    task automatic b_access(input logic w, input logic [19:0] a, output int lat);
        int t0;
        bit got;
        @(posedge clk); #1;
        b_wr = w; b_addr = a; b_be = 2'b11; b_req = 1'b1;
        t0  = cyc;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (b_ack0) got = 1'b1;
        end
        lat = cyc - t0;
        chk("b_ack_arrives", 32'(got), 32'd1);
        @(posedge clk); #1;
        b_req = 1'b0;
    endtask

    // Monitor: scoreboard pops on ACK plus per-cycle bus discipline on both instances.
    int   a_run, a_we_cnt, a_we_last, a_oe_cnt, a_oe_last;
    int   b_run, b_we_cnt, b_we_last, b_oe_cnt, b_oe_last;
    bit   a_run_w, b_run_w;
    logic [1:0] a_be_seen;
    exp_t e_pop;

    always @(negedge clk) begin
        if (rst) begin
            a_run = 0; a_run_w = 0; a_we_cnt = 0; a_oe_cnt = 0;
            b_run = 0; b_run_w = 0; b_we_cnt = 0; b_oe_cnt = 0;
        end else begin
            chk("ack_exclusive", 32'(ack0 & ack1), 32'd0);
            if (ack0) begin
                log_p.push_back(0); log_c.push_back(cyc);
                chk("ack0_expected", 32'(q0.size() != 0), 32'd1);
                if (q0.size() != 0) begin
                    e_pop = q0.pop_front();
                    if (e_pop.rd) chk("rdata0", 32'(rdata0), 32'(e_pop.data));
                end
            end
            if (ack1) begin
                log_p.push_back(1); log_c.push_back(cyc);
                chk("ack1_expected", 32'(q1.size() != 0), 32'd1);
                if (q1.size() != 0) begin
                    e_pop = q1.pop_front();
                    if (e_pop.rd) chk("rdata1", 32'(rdata1), 32'(e_pop.data));
                end
            end
            chk("a_we_oe_excl", 32'(!a_we && !a_oe), 32'd0);
            if (!a_busy) chk("a_ce_idle", 32'(a_ce), 32'd1);
            if (a_ce) chk("a_strobes_off", 32'({a_we, a_oe}), 32'd3);
            if (!a_ce) begin
                a_run++;
                if (!a_we) a_run_w = 1;
            end else if (a_run != 0) begin
                chk("a_ce_len", 32'(a_run), 32'(a_run_w ? WP_A + 2 : RW_A));
                a_run = 0; a_run_w = 0;
            end
            if (!a_we) begin a_we_cnt++; a_be_seen = {a_bhe, a_ble}; end
            else if (a_we_cnt != 0) begin a_we_last = a_we_cnt; a_we_cnt = 0; end
            if (!a_oe) a_oe_cnt++;
            else if (a_oe_cnt != 0) begin a_oe_last = a_oe_cnt; a_oe_cnt = 0; end

            chk("b_ack1_idle", 32'(b_ack1), 32'd0);
            chk("b_we_oe_excl", 32'(!b_we && !b_oe), 32'd0);
            if (!b_busy) chk("b_ce_idle", 32'(b_ce), 32'd1);
            if (b_ce) chk("b_strobes_off", 32'({b_we, b_oe}), 32'd3);
            if (!b_ce && b_oe) chk("b_io_driven", 32'(b_io), 32'(B_WD));
            else               chk("b_io_released", 32'(b_io !== B_WD), 32'd1);
            if (!b_ce) begin
                b_run++;
                if (!b_we) b_run_w = 1;
            end else if (b_run != 0) begin
                chk("b_ce_len", 32'(b_run), 32'(b_run_w ? WP_B + 2 : RW_B));
                b_run = 0; b_run_w = 0;
            end
            if (!b_we) b_we_cnt++;
            else if (b_we_cnt != 0) begin b_we_last = b_we_cnt; b_we_cnt = 0; end
            if (!b_oe) b_oe_cnt++;
            else if (b_oe_cnt != 0) begin b_oe_last = b_oe_cnt; b_oe_cnt = 0; end
        end
    end

    int lat, lat0, lat1, t0, c0, c1;
    bit got;

    initial begin
        rst = 1'b1;
        for (int p = 0; p < 2; p++) begin
            req[p] = 0; wr[p] = 0; addr[p] = '0; wdata[p] = '0; be[p] = '0;
        end
        b_req = 0; b_wr = 0; b_addr = '0; b_be = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_acks", 32'({ack0, ack1}), 32'd0);
        chk("rst_rdata0", 32'(rdata0), 32'd0);
        chk("rst_rdata1", 32'(rdata1), 32'd0);
        chk("rst_sram_a", 32'(a_a), 32'd0);
        chk("rst_strobes", 32'({a_bhe, a_ble, a_ce, a_oe, a_we}), 32'h1f);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_b_outs", 32'({b_ack0, b_ack1, b_busy, b_a}), 32'd0);
        chk("rst_b_rdata", 32'({b_rdata0, b_rdata1}), 32'd0);
        chk("rst_b_strobes", 32'({b_bhe, b_ble, b_ce, b_oe, b_we}), 32'h1f);
        @(posedge clk); #1 rst = 1'b0;

        // Write then read on port 0.
        access(0, 1'b1, 20'h00012, 16'hBEEF, 2'b11, lat);
        chk("wr_latency", 32'(lat), 32'd4);
        chk("we_pulse_width", 32'(a_we_last), 32'd1);
        access(0, 1'b0, 20'h00012, 16'h0, 2'b11, lat);
        chk("rd_latency", 32'(lat), 32'd3);
        chk("rd_beef", 32'(rdata0), 32'hBEEF);

        // Both ports reading from reset: expect 0,1,0,1 at 4-cycle spacing.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        log_p.delete(); log_c.delete();
        for (int i = 0; i < 2; i++) begin
            q0.push_back('{rd: 1'b1, data: ref_rd(20'h00012)});
            q1.push_back('{rd: 1'b1, data: ref_rd(20'h00012)});
        end
        @(posedge clk); #1;
        for (int p = 0; p < 2; p++) begin
            wr[p] = 1'b0; addr[p] = 20'h00012; be[p] = 2'b11; req[p] = 1'b1;
        end
        t0 = cyc; c0 = 0; c1 = 0;
        for (int i = 0; i < 60 && (c0 < 2 || c1 < 2); i++) begin
            @(negedge clk);
            if (ack0) c0++;
            if (ack1) c1++;
            @(posedge clk); #1;
            if (c0 >= 2) req[0] = 1'b0;
            if (c1 >= 2) req[1] = 1'b0;
        end
        chk("rr_ack_count", 32'(log_p.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_p.size(); i++) begin
            chk($sformatf("rr_order_%0d", i), 32'(log_p[i]), 32'(i % 2));
            chk($sformatf("rr_cycle_%0d", i), 32'(log_c[i] - t0), 32'(3 + 4 * i));
        end

        // Byte-lane write on port 1.
        access(0, 1'b1, 20'h00100, 16'hFFFF, 2'b11, lat);
        access(1, 1'b1, 20'h00100, 16'h1234, 2'b01, lat);
        chk("byte_lane_be", 32'(a_be_seen), 32'b10);
        access(1, 1'b0, 20'h00100, 16'h0, 2'b11, lat);
        chk("byte_lane_rd", 32'(rdata1), 32'hFF34);

        // Longer strobes on instance B.
        b_access(1'b1, 20'h00055, lat);
        chk("b_wr_latency", 32'(lat), 32'd6);
        chk("b_we_width", 32'(b_we_last), 32'd3);
        b_access(1'b0, 20'h00055, lat);
        chk("b_rd_latency", 32'(lat), 32'd5);
        chk("b_oe_width", 32'(b_oe_last), 32'd4);

        // Reset during the write pulse: aborted, no ACK, later read still served.
        @(posedge clk); #1;
        wr[0] = 1'b1; addr[0] = 20'h03000; wdata[0] = 16'h5A5A; be[0] = 2'b11; req[0] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (!a_we) got = 1'b1;
        end
        chk("abort_reached_pulse", 32'(got), 32'd1);
        rst = 1'b1; req[0] = 1'b0;
        @(negedge clk);
        chk("abort_we_b", 32'(a_we), 32'd1);
        chk("abort_ce_b", 32'(a_ce), 32'd1);
        chk("abort_busy", 32'(a_busy), 32'd0);
        chk("abort_no_ack", 32'(ack0), 32'd0);
        chk("abort_io_released", 32'(a_io !== 16'h5A5A), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        access(1, 1'b0, 20'h00012, 16'h0, 2'b11, lat);
        chk("post_abort_rd_latency", 32'(lat), 32'd3);

        // Random concurrent traffic on disjoint address halves.
        fork
            for (int i = 0; i < 25; i++) begin
                access(0, 1'($urandom_range(0, 1)), {1'b0, 15'h0, 4'($urandom_range(0, 15))},
                       16'($urandom), 2'($urandom), lat0);
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
            for (int i = 0; i < 25; i++) begin
                access(1, 1'($urandom_range(0, 1)), {1'b1, 15'h0, 4'($urandom_range(0, 15))},
                       16'($urandom), 2'($urandom), lat1);
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
        join
        repeat (4) @(posedge clk);
        chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
